// File: rtl/prim_subreg_pkg.sv
// Shared types for the shadowed software register.
// Holds the software access modes and the two write phases.
package prim_subreg_pkg;

    typedef enum logic [1:0] {
        RW,
        W1S,
        W1C
    } swaccess_e;

    typedef enum logic {
        IDLE,
        STAGED
    } phase_e;

endpackage

// File: rtl/prim_subreg_arb.sv
// Write arbitration and access-mode arithmetic for one register value.
// Ports: we (commit strobe), wd, de, d, q in; wr_en, wr_data out.
module prim_subreg_arb
    import prim_subreg_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter swaccess_e   MODE = RW
) (
    input  logic          we,
    input  logic [DW-1:0] wd,
    input  logic          de,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] q,
    output logic          wr_en,
    output logic [DW-1:0] wr_data
);

    logic [DW-1:0] base;

    always_comb begin
        wr_en   = we | de;
        // A coincident hardware write becomes the base for set/clear modes.
        base    = (de && (MODE != RW)) ? d : q;
        wr_data = d;
        if (we) begin
            case (MODE)
                W1S:     wr_data = base | wd;
                W1C:     wr_data = base & ~wd;
                default: wr_data = wd;
            endcase
        end
    end

endmodule

// File: rtl/prim_subreg_shadow.sv
// Shadowed register: software must write the same value twice to commit.
// Ports: clk_i, rst_i, re, we, wd, de, d in; qe, q, qs, phase, err_* out.
module prim_subreg_shadow
    import prim_subreg_pkg::*;
#(
    parameter int unsigned    DW       = 32,
    parameter string          SWACCESS = "RW",
    parameter logic [DW-1:0]  RESVAL   = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          re,
    input  logic          we,
    input  logic [DW-1:0] wd,
    input  logic          de,
    input  logic [DW-1:0] d,
    output logic          qe,
    output logic [DW-1:0] q,
    output logic [DW-1:0] qs,
    output logic          phase,
    output logic          err_update,
    output logic          err_storage
);

    localparam swaccess_e MODE = (SWACCESS == "W1S") ? W1S :
                                 (SWACCESS == "W1C") ? W1C : RW;

    phase_e        phase_q, phase_d;
    logic [DW-1:0] staged_q, staged_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic          qe_q, qe_d;
    logic          err_update_q, err_update_d;
    logic          err_storage_q, err_storage_d;
    logic          commit;
    logic          mismatch;
    logic          wr_en;
    logic [DW-1:0] wr_data;

    always_comb begin
        commit   = 1'b0;
        mismatch = 1'b0;
        phase_d  = phase_q;
        staged_d = staged_q;
        case (phase_q)
            IDLE: begin
                if (we) begin
                    staged_d = wd;
                    phase_d  = STAGED;
                end
            end
            STAGED: begin
                if (we) begin
                    phase_d  = IDLE;
                    commit   = (wd == staged_q);
                    mismatch = (wd != staged_q);
                end else if (re) begin
                    // A read between the two writes abandons the sequence.
                    phase_d = IDLE;
                end
            end
            default: phase_d = IDLE;
        endcase
    end

    prim_subreg_arb #(
        .DW   (DW),
        .MODE (MODE)
    ) u_arb (
        .we      (commit),
        .wd      (wd),
        .de      (de),
        .d       (d),
        .q       (q_q),
        .wr_en   (wr_en),
        .wr_data (wr_data)
    );

    always_comb begin
        q_d           = wr_en ? wr_data : q_q;
        shadow_d      = wr_en ? ~wr_data : shadow_q;
        qe_d          = commit;
        err_update_d  = mismatch;
        // Sticky: any disagreement between the copies is a storage fault.
        err_storage_d = err_storage_q | (q_q != ~shadow_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q       <= IDLE;
            staged_q      <= RESVAL;
            q_q           <= RESVAL;
            shadow_q      <= ~RESVAL;
            qe_q          <= 1'b0;
            err_update_q  <= 1'b0;
            err_storage_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            staged_q      <= staged_d;
            q_q           <= q_d;
            shadow_q      <= shadow_d;
            qe_q          <= qe_d;
            err_update_q  <= err_update_d;
            err_storage_q <= err_storage_d;
        end
    end

    assign q           = q_q;
    assign qs          = q_q;
    assign qe          = qe_q;
    assign phase       = phase_q;
    assign err_update  = err_update_q;
    assign err_storage = err_storage_q;

endmodule

// File: tb/tb_prim_subreg_shadow.sv
// Bench for prim_subreg_shadow: RW, W1S and W1C instances share stimulus.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_prim_subreg_shadow;

    localparam logic [7:0] RV0 = 8'hA5;
    localparam logic [7:0] RV1 = 8'h3C;
    localparam logic [7:0] RV2 = 8'hC3;

    logic       clk = 1'b0;
    logic       rst, re, we, de;
    logic [7:0] wd, d;

    logic       qe_o [3];
    logic [7:0] q_o  [3];
    logic [7:0] qs_o [3];
    logic       ph_o [3];
    logic       eu_o [3];
    logic       es_o [3];

    logic [7:0] mq  [3];
    logic [7:0] mst [3];
    bit         mph [3];
    bit         mqe [3];
    bit         meu [3];
    bit         mes [3];
    bit         bad [3];

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] fv;

    always #5 clk = ~clk;

    prim_subreg_shadow #(.DW(8), .SWACCESS("RW"), .RESVAL(RV0)) u_rw (
        .clk_i(clk), .rst_i(rst), .re(re), .we(we), .wd(wd), .de(de), .d(d),
        .qe(qe_o[0]), .q(q_o[0]), .qs(qs_o[0]), .phase(ph_o[0]),
        .err_update(eu_o[0]), .err_storage(es_o[0])
    );

    prim_subreg_shadow #(.DW(8), .SWACCESS("W1S"), .RESVAL(RV1)) u_w1s (
        .clk_i(clk), .rst_i(rst), .re(re), .we(we), .wd(wd), .de(de), .d(d),
        .qe(qe_o[1]), .q(q_o[1]), .qs(qs_o[1]), .phase(ph_o[1]),
        .err_update(eu_o[1]), .err_storage(es_o[1])
    );

    prim_subreg_shadow #(.DW(8), .SWACCESS("W1C"), .RESVAL(RV2)) u_w1c (
        .clk_i(clk), .rst_i(rst), .re(re), .we(we), .wd(wd), .de(de), .d(d),
        .qe(qe_o[2]), .q(q_o[2]), .qs(qs_o[2]), .phase(ph_o[2]),
        .err_update(eu_o[2]), .err_storage(es_o[2])
    );

    function automatic logic [7:0] rv(input int k);
        return (k == 0) ? RV0 : (k == 1) ? RV1 : RV2;
    endfunction

    function automatic logic [7:0] mode_fn(input int k, input logic [7:0] b,
                                           input logic [7:0] w);
        if (k == 0) return w;
        if (k == 1) return b | w;
        return b & ~w;
    endfunction

    // One clock: apply inputs, advance the reference model at the edge.
    task automatic step(input logic r, input logic rd, input logic w,
                        input logic [7:0] wdat, input logic h,
                        input logic [7:0] hdat);
        bit cm;
        rst = r; re = rd; we = w; wd = wdat; de = h; d = hdat;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                mq[k] = rv(k); mst[k] = rv(k); mph[k] = 0;
                mqe[k] = 0; meu[k] = 0; mes[k] = 0; bad[k] = 0;
            end else begin
                cm = mph[k] && w && (wdat == mst[k]);
                mes[k] = mes[k] | bad[k];
                meu[k] = mph[k] && w && !cm;
                mqe[k] = cm;
                if (cm) begin
                    mq[k] = mode_fn(k, (h && k != 0) ? hdat : mq[k], wdat);
                    bad[k] = 0;
                end else if (h) begin
                    mq[k] = hdat;
                    bad[k] = 0;
                end
                if (!mph[k]) begin
                    if (w) begin mst[k] = wdat; mph[k] = 1; end
                end else if (w || rd) begin
                    mph[k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic wr(input logic [7:0] v);
        step(0, 0, 1, v, 0, 8'h00);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 8'h00, 0, 8'h00);
        step(1, 0, 1, 8'hFF, 1, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (q_o[k] !== rv(k) || qs_o[k] !== rv(k)) begin
                n_err++;
                $display("FAIL reset_q[%0d] got %h/%h want %h", k, q_o[k], qs_o[k], rv(k));
            end
            n_vec++;
            if ({qe_o[k], ph_o[k], eu_o[k], es_o[k]} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_flags[%0d] got %b want 0000", k,
                         {qe_o[k], ph_o[k], eu_o[k], es_o[k]});
            end
        end
    endtask

    task automatic test_commit();
        step(1, 0, 0, 8'h00, 0, 8'h00);
        wr(8'h5A);
        n_vec++;
        if ({ph_o[0], qe_o[0]} !== 2'b10 || q_o[0] !== RV0) begin
            n_err++;
            $display("FAIL stage1 got ph=%b qe=%b q=%h want ph=1 qe=0 q=%h", ph_o[0], qe_o[0], q_o[0], RV0);
        end
        wr(8'h5A);
        n_vec++;
        if ({ph_o[0], qe_o[0]} !== 2'b01 || q_o[0] !== 8'h5A || qs_o[0] !== 8'h5A) begin
            n_err++;
            $display("FAIL commit got ph=%b qe=%b q=%h qs=%h want ph=0 qe=1 q=5a", ph_o[0], qe_o[0], q_o[0], qs_o[0]);
        end
        idle();
        n_vec++;
        if (qe_o[0] !== 1'b0 || q_o[0] !== 8'h5A) begin
            n_err++;
            $display("FAIL qe_once got qe=%b q=%h want qe=0 q=5a", qe_o[0], q_o[0]);
        end
    endtask

    task automatic test_mismatch();
        step(1, 0, 0, 8'h00, 0, 8'h00);
        wr(8'h5A);
        wr(8'h5B);
        n_vec++;
        if (eu_o[0] !== 1'b1 || q_o[0] !== RV0 || ph_o[0] !== 1'b0 || qe_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL mismatch got eu=%b q=%h ph=%b qe=%b want eu=1 q=%h ph=0 qe=0", eu_o[0], q_o[0], ph_o[0], qe_o[0], RV0);
        end
        idle();
        n_vec++;
        if (eu_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL eu_once got %b want 0", eu_o[0]);
        end
    endtask

    task automatic test_w1c();
        step(1, 0, 0, 8'h00, 0, 8'h00);
        step(0, 0, 0, 8'h00, 1, 8'hFF);
        wr(8'h0F);
        wr(8'h0F);
        n_vec++;
        if (q_o[2] !== 8'hF0 || qe_o[2] !== 1'b1) begin
            n_err++;
            $display("FAIL w1c_commit got q=%h qe=%b want q=f0 qe=1", q_o[2], qe_o[2]);
        end
        step(0, 0, 0, 8'h00, 1, 8'hFF);
        wr(8'h0F);
        idle();
        idle();
        n_vec++;
        if (q_o[2] !== 8'hFF || ph_o[2] !== 1'b1) begin
            n_err++;
            $display("FAIL w1c_single got q=%h ph=%b want q=ff ph=1", q_o[2], ph_o[2]);
        end
        step(0, 1, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic test_abort();
        step(1, 0, 0, 8'h00, 0, 8'h00);
        wr(8'h11);
        step(0, 1, 0, 8'h00, 0, 8'h00);
        n_vec++;
        if (ph_o[0] !== 1'b0 || eu_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort got ph=%b eu=%b want ph=0 eu=0", ph_o[0], eu_o[0]);
        end
        wr(8'h11);
        n_vec++;
        if (ph_o[0] !== 1'b1 || qe_o[0] !== 1'b0 || q_o[0] !== RV0) begin
            n_err++;
            $display("FAIL restage got ph=%b qe=%b q=%h want ph=1 qe=0 q=%h", ph_o[0], qe_o[0], q_o[0], RV0);
        end
    endtask

    task automatic test_hw_staged();
        step(1, 0, 0, 8'h00, 0, 8'h00);
        wr(8'h22);
        step(0, 0, 0, 8'h00, 1, 8'h33);
        n_vec++;
        if (q_o[0] !== 8'h33 || ph_o[0] !== 1'b1 || qe_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL hw_write got q=%h ph=%b qe=%b want q=33 ph=1 qe=0", q_o[0], ph_o[0], qe_o[0]);
        end
        wr(8'h22);
        n_vec++;
        if (q_o[0] !== 8'h22 || qe_o[0] !== 1'b1 || ph_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL hw_then_commit got q=%h qe=%b ph=%b want q=22 qe=1 ph=0", q_o[0], qe_o[0], ph_o[0]);
        end
        n_vec++;
        if (q_o[1] !== 8'h33) begin
            n_err++;
            $display("FAIL w1s_commit got %h want 33", q_o[1]);
        end
    endtask

    task automatic test_collision();
        step(1, 0, 0, 8'h00, 0, 8'h00);
        wr(8'h0F);
        step(0, 0, 1, 8'h0F, 1, 8'hF0);
        n_vec++;
        if (q_o[0] !== 8'h0F || q_o[1] !== 8'hFF || q_o[2] !== 8'hF0) begin
            n_err++;
            $display("FAIL collision got %h/%h/%h want 0f/ff/f0", q_o[0], q_o[1], q_o[2]);
        end
    endtask

    task automatic test_storage();
        step(1, 0, 0, 8'h00, 0, 8'h00);
        fv = ~RV0 ^ 8'h10;
        force u_rw.shadow_q = fv;
        bad[0] = 1;
        idle();
        n_vec++;
        if (es_o[0] !== 1'b1 || es_o[1] !== 1'b0) begin
            n_err++;
            $display("FAIL storage_set got %b/%b want 1/0", es_o[0], es_o[1]);
        end
        idle();
        release u_rw.shadow_q;
        step(0, 0, 0, 8'h00, 1, 8'h77);
        idle();
        n_vec++;
        if (es_o[0] !== 1'b1 || q_o[0] !== 8'h77) begin
            n_err++;
            $display("FAIL storage_sticky got es=%b q=%h want es=1 q=77", es_o[0], q_o[0]);
        end
        step(1, 0, 0, 8'h00, 0, 8'h00);
        n_vec++;
        if (es_o[0] !== 1'b0 || q_o[0] !== RV0) begin
            n_err++;
            $display("FAIL storage_clear got es=%b q=%h want es=0 q=%h", es_o[0], q_o[0], RV0);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [4];
        pool[0] = 8'h5A; pool[1] = 8'h5B; pool[2] = 8'hA5; pool[3] = 8'hFF;
        step(1, 0, 0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, pool[$urandom_range(0, 3)],
                 $urandom_range(0, 3) == 0, 8'($urandom));
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (q_o[k] !== mq[k] || qs_o[k] !== mq[k] || qe_o[k] !== mqe[k] ||
                    ph_o[k] !== mph[k] || eu_o[k] !== meu[k] || es_o[k] !== mes[k]) begin
                    n_err++;
                    $display("FAIL rand[%0d] inst%0d got q=%h qs=%h qe=%b ph=%b eu=%b es=%b want q=%h qe=%b ph=%b eu=%b es=%b",
                             i, k, q_o[k], qs_o[k], qe_o[k], ph_o[k], eu_o[k], es_o[k],
                             mq[k], mqe[k], mph[k], meu[k], mes[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1; re = 0; we = 0; de = 0; wd = 0; d = 0;
        test_reset();
        test_commit();
        test_mismatch();
        test_w1c();
        test_abort();
        test_hw_staged();
        test_collision();
        test_storage();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prim_subreg_shadow.md
PRIM_SUBREG_SHADOW -- requirements
Module: prim_subreg_shadow

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the register data width in bits (1..32).
REQ-002 The block SHALL have parameter SWACCESS, default "RW", meaning the software access mode, one of {"RW", "W1S", "W1C"}.
REQ-003 The block SHALL have parameter RESVAL, default '0, meaning the DW-bit reset value of the committed register.
REQ-004 The block SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port re  input  1  software read strobe.
REQ-007 The block SHALL have port we  input  1  software write strobe.
REQ-008 The block SHALL have port wd  input  DW  software write data.
REQ-009 The block SHALL have port de  input  1  hardware write enable.
REQ-010 The block SHALL have port d  input  DW  hardware write data.
REQ-011 The block SHALL have port qe  output  1  committed-write pulse.
REQ-012 The block SHALL have port q  output  DW  committed value to hardware.
REQ-013 The block SHALL have port qs  output  DW  committed value to the register read path.
REQ-014 The block SHALL have port phase  output  1  write phase: 0 = IDLE, 1 = STAGED.
REQ-015 The block SHALL have port err_update  output  1  one-cycle mismatch pulse.
REQ-016 The block SHALL have port err_storage  output  1  sticky storage-fault flag.

Function
REQ-017 Internal state SHALL be: committed q, shadow register holding ~q, staged register, and a 2-state FSM (IDLE, STAGED).
REQ-018 In IDLE, we=1 SHALL load wd into staged, move to STAGED, and leave q unchanged.
REQ-019 In STAGED with we=1 and wd==staged, the block SHALL commit: q <= mode(q, wd), shadow <= ~mode(q, wd), and the FSM returns to IDLE.
REQ-020 In STAGED with we=1 and wd!=staged, q SHALL be unchanged, the FSM SHALL return to IDLE, and err_update SHALL be 1 for exactly the next cycle.
REQ-021 In STAGED with re=1 and we=0, the FSM SHALL abort to IDLE without error.
REQ-022 mode() SHALL be: RW -> wd; W1S -> q|wd; W1C -> q&~wd.
REQ-023 When de=1 in either phase without a same-cycle commit, q SHALL take d and shadow SHALL take ~d; the phase is unaffected.
REQ-024 If de=1 coincides with a commit, software SHALL win for RW; W1S/W1C SHALL apply mode() to d instead of q.
REQ-025 qe SHALL be registered and high for exactly the cycle after a commit edge; it SHALL NOT assert on a hardware write or a staging write.
REQ-026 qs SHALL equal q at all times; the q update becomes visible one cycle after the commit edge.
REQ-027 err_storage SHALL set on the edge after q!=~shadow is detected and remain set until reset.
REQ-028 phase SHALL reflect the FSM state registered, with no combinational path from we.

Reset
REQ-029 While rst_i=1 at a clock edge, the block SHALL set q=RESVAL, shadow=~RESVAL, staged=RESVAL, phase=IDLE, and qe=err_update=err_storage=0.
REQ-030 A reset asserted mid-sequence (STAGED) SHALL discard the staged value and any pending commit.

Structure
REQ-031 Package prim_subreg_pkg SHALL hold the swaccess_e enum (RW, W1S, W1C) and the phase_e enum (IDLE, STAGED).
REQ-032 Mode arithmetic SHALL live in one combinational sub-module, prim_subreg_arb (inputs we, wd, de, d, q; outputs wr_en, wr_data), instantiated once for the committed value; the shadow path SHALL use the inverted result.

Verification
REQ-033 The bench SHALL cover: DW=8 RW; write 0x5A, then write 0x5A -> qe pulses once, q=0x5A, phase 1 then 0.
REQ-034 The bench SHALL cover: write 0x5A, then write 0x5B -> err_update high for one cycle, q stays at RESVAL, phase=0.
REQ-035 The bench SHALL cover: W1C with q=0xFF; write 0x0F twice -> q=0xF0; a single write only -> q=0xFF.
REQ-036 The bench SHALL cover: write 0x11, re=1, then write 0x11 -> the second write only stages, no qe, phase=1.
REQ-037 The bench SHALL cover: de=1 with d=0x33 while STAGED -> q=0x33, phase stays 1; a matching second write then commits.
REQ-038 The bench SHALL cover: force a shadow bit flip -> err_storage=1 next cycle and it stays set; rst_i clears it, and q returns to RESVAL.
